batch_slot_allocator: RTL and testbench
=======================================

Name: batch_slot_allocator

Overview:
- Circular-queue slot allocator for multi-lane dispatch. Each cycle it grants 0..WIDTH consecutive entries at the tail and frees 0..WIDTH entries at the head.
- It sequences the count-to-thermometer expander (expand_one, instantiated internally) to produce the per-lane grant mask.
- It sits between rename/dispatch (requester) and an in-order buffer such as a ROB or store queue (resource).

Parameters:
- WIDTH, 8: lanes per cycle; maximum alloc/release count.
- DEPTH, 32: queue entries; power of two, DEPTH >= WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  requester presents a request.
- alloc_req_num  in  $clog2(WIDTH)+1  entries requested, 0..WIDTH.
- alloc_ready  out  1  request can be accepted this cycle.
- alloc_lane_mask  out  WIDTH  thermometer mask of granted lanes (bit i = lane i granted).
- alloc_start_idx  out  $clog2(DEPTH)  entry index of lane 0; lane i owns (start+i) mod DEPTH.
- alloc_start_wrap  out  1  wrap bit of the tail pointer.
- release_num  in  $clog2(WIDTH)+1  entries retired at head, 0..WIDTH.
- flush  in  1  discard all allocated, unreleased entries.
- free_count  out  $clog2(DEPTH)+1  DEPTH - used.
- empty  out  1  used == 0.
- full  out  1  used == DEPTH.
- err_over_release  out  1  sticky protocol-error flag.

Behaviour:
- State:
  - head_ptr and tail_ptr, each $clog2(DEPTH)+1 bits (index plus wrap bit).
  - used = tail_ptr - head_ptr, modulo 2*DEPTH.
  - FSM with states NORMAL and RECOVER.
- Reset (rst low, async): head = tail = 0, FSM = NORMAL, err = 0. Resulting outputs:
  - free_count = DEPTH, empty = 1, full = 0.
  - alloc_ready = 1, alloc_lane_mask = 0, start idx/wrap = 0.
- Request clamping: req_eff = min(alloc_req_num, WIDTH). Values > WIDTH are saturated to WIDTH.
- alloc_ready (combinational from registered state only) = (FSM == NORMAL) && (free_count >= req_eff) && !flush.
  - No same-cycle bypass from release_num.
- Fire = alloc_valid && alloc_ready.
- alloc_lane_mask:
  - Equals expand_one(req_eff) when fire, else 0.
  - Combinational, zero-latency with respect to the request.
- alloc_start_idx/wrap = tail_ptr, combinational, always driven.
- Release:
  - rel_eff = min(release_num, used). head += rel_eff at the clock edge.
  - If release_num > used, err_over_release is set and held until reset.
  - Release is processed in every FSM state.
- Allocate: on fire, tail += req_eff at the clock edge.
- A fire with req_eff = 0 is legal and changes no state.
- Simultaneous alloc and release:
  - Both apply in the same edge.
  - free_count next = free_count - req_eff + rel_eff.
- Flush:
  - At the edge: head += rel_eff, then tail := new head (used = 0).
  - FSM goes to RECOVER. Any request in the flush cycle is not accepted (ready = 0).
- RECOVER:
  - alloc_ready = 0 for exactly one cycle, then return to NORMAL.
  - A flush while in RECOVER re-enters RECOVER.
- Wrap-around: pointer arithmetic is modulo 2*DEPTH. Grants may straddle index DEPTH-1 to 0 with no special handling.
- full/empty/free_count are derived combinationally from the registered pointers.
- Reset asserted mid-operation immediately forces all reset values, independent of clk.

Test Plan (WIDTH=8, DEPTH=32):
1. Reset, then idle one cycle -> free_count=32, empty=1, full=0, alloc_ready=1, mask=0, start_idx=0, err=0.
2. alloc 3:
   - Same cycle: mask=8'b00000111, start_idx=0.
   - Next cycle: alloc 8 -> mask=8'hFF, start_idx=3.
   - After that: free_count=21.
3. Four allocs of 8 -> full=1, free_count=0.
   - alloc 1 with release 8 in the same cycle -> alloc_ready=0.
   - Next cycle: free_count=8, ready=1.
4. Wrap:
   - Alloc 30 (four bursts of 8/8/8/6), release 30, then alloc 5 -> start_idx=30, wrap=0.
   - Next tail_idx=3, wrap=1; free_count=27.
5. Flush with used=10, release 2, alloc_valid=1 req 4:
   - Same cycle: ready=0.
   - Next cycle: empty=1, start_idx = old head+2, ready=0 (RECOVER).
   - Following cycle: ready=1.
6. Over-release and async reset:
   - used=3, release 5 -> used=0 and err_over_release=1, still 1 after 5 idle cycles.
   - Assert rst between edges -> err=0 and free_count=32 immediately.

Source files
------------

// File: rtl/batch_slot_allocator.sv
// batch_slot_allocator: circular-queue slot allocator granting/freeing up to WIDTH entries per cycle
module expand_one #(
  parameter int WIDTH = 8,
  parameter int CW = $clog2(WIDTH) + 1
) (
  input  logic [CW-1:0]    num,
  output logic [WIDTH-1:0] mask
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign mask[i] = num > CW'(i);
  end
endmodule

module batch_slot_allocator #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  input  logic [$clog2(WIDTH):0]   alloc_req_num,
  output logic                     alloc_ready,
  output logic [WIDTH-1:0]         alloc_lane_mask,
  output logic [$clog2(DEPTH)-1:0] alloc_start_idx,
  output logic                     alloc_start_wrap,
  input  logic [$clog2(WIDTH):0]   release_num,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   free_count,
  output logic                     empty,
  output logic                     full,
  output logic                     err_over_release
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  typedef enum logic {NORMAL, RECOVER} state_t;
  state_t state, state_next;
  logic [PW-1:0] head, tail, used, rel_eff;
  logic [CW-1:0] req_eff;
  logic [WIDTH-1:0] thermo;
  logic fire, over;
  expand_one #(.WIDTH(WIDTH), .CW(CW)) u_expand (.num(req_eff), .mask(thermo));
  // ready depends only on registered state and flush; releases free space a cycle later
  always_comb begin
    used = tail - head;
    free_count = PW'(DEPTH) - used;
    req_eff = alloc_req_num > CW'(WIDTH) ? CW'(WIDTH) : alloc_req_num;
    over = PW'(release_num) > used;
    rel_eff = over ? used : PW'(release_num);
    alloc_ready = state == NORMAL && free_count >= PW'(req_eff) && !flush;
    fire = alloc_valid && alloc_ready;
    alloc_lane_mask = fire ? thermo : '0;
    state_next = flush ? RECOVER : NORMAL;
  end
  assign alloc_start_idx = tail[IW-1:0];
  assign alloc_start_wrap = tail[IW];
  assign empty = used == '0;
  assign full = used == PW'(DEPTH);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= NORMAL;
      head <= '0;
      tail <= '0;
      err_over_release <= 1'b0;
    end else begin
      state <= state_next;
      head <= head + rel_eff;
      tail <= flush ? head + rel_eff : tail + (fire ? PW'(req_eff) : '0);
      err_over_release <= err_over_release | over;
    end
  end
endmodule

// File: tb/tb_batch_slot_allocator.sv
// tb_batch_slot_allocator: directed stimulus with queued expectations checked by a negedge monitor
module tb_batch_slot_allocator;
  logic clk = 0, rst = 0, alloc_valid = 0, flush = 0;
  logic [3:0] alloc_req_num = 0, release_num = 0;
  logic alloc_ready, alloc_start_wrap, empty, full, err_over_release;
  logic [7:0] alloc_lane_mask;
  logic [4:0] alloc_start_idx;
  logic [5:0] free_count;
  int checks = 0, failures = 0;

  typedef struct {
    string name;
    logic [7:0] chk;
    logic rdy;
    logic [7:0] mask;
    logic [4:0] idx;
    logic wrap;
    logic [5:0] free;
    logic emp, ful, err;
  } exp_t;
  exp_t q[$];

  batch_slot_allocator #(.WIDTH(8), .DEPTH(32)) dut (
    .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_req_num(alloc_req_num),
    .alloc_ready(alloc_ready), .alloc_lane_mask(alloc_lane_mask),
    .alloc_start_idx(alloc_start_idx), .alloc_start_wrap(alloc_start_wrap),
    .release_num(release_num), .flush(flush), .free_count(free_count),
    .empty(empty), .full(full), .err_over_release(err_over_release)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string n, input string f, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%0h exp=%0h", n, f, got, exp);
    end
  endtask

  // chk bits: 0 ready, 1 mask, 2 idx, 3 wrap, 4 free, 5 empty, 6 full, 7 err
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk[0]) cmp(e.name, "ready", {7'b0, alloc_ready}, {7'b0, e.rdy});
      if (e.chk[1]) cmp(e.name, "mask", alloc_lane_mask, e.mask);
      if (e.chk[2]) cmp(e.name, "idx", {3'b0, alloc_start_idx}, {3'b0, e.idx});
      if (e.chk[3]) cmp(e.name, "wrap", {7'b0, alloc_start_wrap}, {7'b0, e.wrap});
      if (e.chk[4]) cmp(e.name, "free", {2'b0, free_count}, {2'b0, e.free});
      if (e.chk[5]) cmp(e.name, "empty", {7'b0, empty}, {7'b0, e.emp});
      if (e.chk[6]) cmp(e.name, "full", {7'b0, full}, {7'b0, e.ful});
      if (e.chk[7]) cmp(e.name, "err", {7'b0, err_over_release}, {7'b0, e.err});
    end
  end

  task automatic drive(input logic v, input logic [3:0] r, input logic [3:0] rl, input logic f);
    @(posedge clk);
    #1;
    rst = 1;
    alloc_valid = v;
    alloc_req_num = r;
    release_num = rl;
    flush = f;
  endtask

  task automatic push(input string n, input logic [7:0] c, input logic rdy, input logic [7:0] m,
                      input logic [4:0] i, input logic w, input logic [5:0] fr,
                      input logic em, input logic fu, input logic er);
    exp_t e;
    e.name = n; e.chk = c; e.rdy = rdy; e.mask = m; e.idx = i; e.wrap = w;
    e.free = fr; e.emp = em; e.ful = fu; e.err = er;
    q.push_back(e);
  endtask

  // reset asserted mid-cycle; the negedge sample precedes any further rising edge
  task automatic do_reset(input string n);
    @(posedge clk);
    #1;
    rst = 0;
    alloc_valid = 0; alloc_req_num = 0; release_num = 0; flush = 0;
    push(n, 8'hFF, 1, 8'h00, 0, 0, 32, 1, 0, 0);
  endtask

  initial begin
    do_reset("rst0");
    drive(0, 0, 0, 0); push("idle", 8'hFF, 1, 8'h00, 0, 0, 32, 1, 0, 0);
    drive(1, 3, 0, 0); push("a3", 8'h17, 1, 8'h07, 0, 0, 32, 0, 0, 0);
    drive(1, 8, 0, 0); push("a8", 8'h17, 1, 8'hFF, 3, 0, 29, 0, 0, 0);
    drive(0, 0, 0, 0); push("after_a8", 8'h17, 1, 8'h00, 11, 0, 21, 0, 0, 0);
    drive(0, 0, 8, 0); push("rel8", 8'h10, 0, 0, 0, 0, 21, 0, 0, 0);
    drive(0, 0, 3, 0); push("rel3", 8'h10, 0, 0, 0, 0, 29, 0, 0, 0);
    drive(1, 8, 0, 0); push("fill0", 8'h1F, 1, 8'hFF, 11, 0, 32, 0, 0, 0);
    drive(1, 8, 0, 0); push("fill1", 8'h1F, 1, 8'hFF, 19, 0, 24, 0, 0, 0);
    drive(1, 8, 0, 0); push("fill2", 8'h1F, 1, 8'hFF, 27, 0, 16, 0, 0, 0);
    drive(1, 8, 0, 0); push("fill3", 8'h1F, 1, 8'hFF, 3, 1, 8, 0, 0, 0);
    drive(1, 1, 8, 0); push("full_blk", 8'h53, 0, 8'h00, 0, 0, 0, 0, 1, 0);
    drive(1, 1, 0, 0); push("post_rel", 8'h1F, 1, 8'h01, 11, 1, 8, 0, 0, 0);
    do_reset("rst1");
    drive(1, 8, 0, 0); push("w0", 8'h1F, 1, 8'hFF, 0, 0, 32, 0, 0, 0);
    drive(1, 8, 0, 0); push("w1", 8'h1F, 1, 8'hFF, 8, 0, 24, 0, 0, 0);
    drive(1, 8, 0, 0); push("w2", 8'h1F, 1, 8'hFF, 16, 0, 16, 0, 0, 0);
    drive(1, 6, 0, 0); push("w3", 8'h1F, 1, 8'h3F, 24, 0, 8, 0, 0, 0);
    drive(0, 0, 8, 0); push("wr0", 8'h10, 0, 0, 0, 0, 2, 0, 0, 0);
    drive(0, 0, 8, 0); push("wr1", 8'h10, 0, 0, 0, 0, 10, 0, 0, 0);
    drive(0, 0, 8, 0); push("wr2", 8'h10, 0, 0, 0, 0, 18, 0, 0, 0);
    drive(0, 0, 6, 0); push("wr3", 8'h10, 0, 0, 0, 0, 26, 0, 0, 0);
    drive(1, 5, 0, 0); push("wa5", 8'h1F, 1, 8'h1F, 30, 0, 32, 0, 0, 0);
    drive(1, 5, 0, 0); push("wrapped", 8'h1F, 1, 8'h1F, 3, 1, 27, 0, 0, 0);
    drive(1, 4, 2, 1); push("flush", 8'h13, 0, 8'h00, 0, 0, 22, 0, 0, 0);
    drive(1, 4, 0, 0); push("recover", 8'h3F, 0, 8'h00, 0, 1, 32, 1, 0, 0);
    drive(1, 4, 0, 0); push("resume", 8'h1F, 1, 8'h0F, 0, 1, 32, 0, 0, 0);
    drive(0, 0, 1, 0); push("used4", 8'h10, 0, 0, 0, 0, 28, 0, 0, 0);
    drive(0, 0, 5, 0); push("over_rel", 8'h90, 0, 0, 0, 0, 29, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0); push("err_hold", 8'hB0, 0, 0, 0, 0, 32, 1, 0, 1);
    end
    do_reset("async_rst");
    drive(1, 12, 0, 0); push("clamp", 8'h17, 1, 8'hFF, 0, 0, 32, 0, 0, 0);
    drive(1, 0, 0, 0); push("zero_req", 8'h17, 1, 8'h00, 8, 0, 24, 0, 0, 0);
    drive(0, 0, 0, 0); push("zero_after", 8'h17, 1, 8'h00, 8, 0, 24, 0, 0, 0);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
